// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory bus between instruction fetch and MEM stage
// MEM has priority; a done pulse blocks a re-grant to that port until the pipeline advances.

module mem_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stallreq,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [3:0]        mem_sel,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_stallreq,
   input  logic              flush,
   output logic              bus_req,
   output logic              bus_we,
   output logic [3:0]        bus_sel,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_IF_BUSY  = 2'd1;
   localparam logic [1:0] S_MEM_BUSY = 2'd2;
   localparam logic [1:0] S_DISCARD  = 2'd3;

   logic [1:0]        r_state;
   logic              r_bus_req;
   logic              r_bus_we;
   logic [3:0]        r_bus_sel;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_bus_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_mem_rdata;
   logic              r_if_done;
   logic              r_mem_done;
   logic              r_mem_flushed;

   logic w_grant_mem;
   logic w_grant_if;
   logic w_mem_drop;

   assign w_grant_mem = ~flush & mem_req & ~r_mem_done;
   assign w_grant_if  = ~flush & ~w_grant_mem & if_req & ~r_if_done;
   // A flush seen at any point of a data access suppresses its completion.
   assign w_mem_drop  = flush | r_mem_flushed;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_bus_req     <= 1'b0;
         r_bus_we      <= 1'b0;
         r_bus_sel     <= 4'h0;
         r_bus_addr    <= '0;
         r_bus_wdata   <= '0;
         r_if_rdata    <= '0;
         r_mem_rdata   <= '0;
         r_if_done     <= 1'b0;
         r_mem_done    <= 1'b0;
         r_mem_flushed <= 1'b0;
      end else begin
         r_if_done  <= 1'b0;
         r_mem_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_mem) begin
                  r_state       <= S_MEM_BUSY;
                  r_bus_req     <= 1'b1;
                  r_bus_we      <= mem_we;
                  r_bus_sel     <= mem_sel;
                  r_bus_addr    <= mem_addr;
                  r_bus_wdata   <= mem_wdata;
                  r_mem_flushed <= 1'b0;
               end else if (w_grant_if) begin
                  r_state    <= S_IF_BUSY;
                  r_bus_req  <= 1'b1;
                  r_bus_we   <= 1'b0;
                  r_bus_sel  <= 4'hF;
                  r_bus_addr <= if_addr;
               end
            end
            S_IF_BUSY: begin
               if (bus_ack) begin
                  r_state   <= S_IDLE;
                  r_bus_req <= 1'b0;
                  if (!flush) begin
                     r_if_rdata <= bus_rdata;
                     r_if_done  <= 1'b1;
                  end
               end else if (flush) begin
                  r_state <= S_DISCARD;
               end
            end
            S_MEM_BUSY: begin
               if (bus_ack) begin
                  r_state       <= S_IDLE;
                  r_bus_req     <= 1'b0;
                  r_mem_flushed <= 1'b0;
                  if (!w_mem_drop) begin
                     r_mem_done <= 1'b1;
                     if (!r_bus_we) begin
                        r_mem_rdata <= bus_rdata;
                     end
                  end
               end else if (flush) begin
                  r_mem_flushed <= 1'b1;
               end
            end
            S_DISCARD: begin
               if (bus_ack) begin
                  r_state   <= S_IDLE;
                  r_bus_req <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign if_stallreq  = if_req & ~r_if_done;
   assign mem_stallreq = mem_req & ~r_mem_done;
   assign if_rdata     = r_if_rdata;
   assign mem_rdata    = r_mem_rdata;
   assign bus_req      = r_bus_req;
   assign bus_we       = r_bus_we;
   assign bus_sel      = r_bus_sel;
   assign bus_addr     = r_bus_addr;
   assign bus_wdata    = r_bus_wdata;

endmodule
